// File: rtl/sub4_pkg.sv
// Shared widths, accumulator limits and the decoded result record for the sub4 result stage.
package sub4_pkg;
  localparam int DIFF_W  = 5;
  localparam int MAG_W   = 4;
  localparam int ACC_W   = 8;
  localparam int ACC_MAX = 127;
  localparam int ACC_MIN = -128;

  typedef struct packed {
    logic              neg;
    logic [MAG_W-1:0]  mag;
    logic              zero;
    logic [DIFF_W-1:0] sval;
  } result_t;

  localparam int RES_W = $bits(result_t);

  // The subtractor word is A-B+16, so the carry bit is the inverted sign.
  function automatic result_t decode(input logic [DIFF_W-1:0] d);
    result_t r;
    r.neg  = ~d[DIFF_W-1];
    r.sval = {~d[DIFF_W-1], d[MAG_W-1:0]};
    r.mag  = r.neg ? (~d[MAG_W-1:0] + 1'b1) : d[MAG_W-1:0];
    r.zero = (d == {1'b1, {MAG_W{1'b0}}});
    return r;
  endfunction
endpackage

// File: rtl/sub4_fifo.sv
// Result FIFO: power-of-two storage with wrapping pointers and an occupancy count.
module sub4_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/sub4_result_stage.sv
// Decodes subtractor words into sign/magnitude/zero/value records and queues them.
// Optional running saturating accumulator enabled by defining SUB4_ACCUM_EN.
module sub4_result_stage
  import sub4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DIFF_W-1:0] in_diff,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_neg,
  output logic [MAG_W-1:0]  out_mag,
  output logic              out_zero,
  output logic [DIFF_W-1:0] out_sval
`ifdef SUB4_ACCUM_EN
  ,
  input  logic              acc_clr,
  output logic signed [ACC_W-1:0] acc_out,
  output logic              acc_sat
`endif
);
  result_t dec_w;
  result_t head_w;
  logic    full_w, empty_w;
  logic    push_w, pop_w;

  assign dec_w     = decode(in_diff);
  assign in_ready  = !full_w;
  assign out_valid = !empty_w;
  assign push_w    = in_valid && in_ready;
  assign pop_w     = out_valid && out_ready;

  sub4_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .wdata_i (dec_w),
    .rdata_o (head_w),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  always_comb begin
    out_neg  = 1'b0;
    out_mag  = '0;
    out_zero = 1'b0;
    out_sval = '0;
    if (out_valid) begin
      out_neg  = head_w.neg;
      out_mag  = head_w.mag;
      out_zero = head_w.zero;
      out_sval = head_w.sval;
    end
  end

`ifdef SUB4_ACCUM_EN
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic [ACC_W:0]          add_w;

  // Returns {saturated, clamped sum}.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic [DIFF_W-1:0] b);
    logic signed [ACC_W:0] sum;
    sum = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W+1-DIFF_W){b[DIFF_W-1]}}, b});
    if (sum > $signed((ACC_W+1)'(ACC_MAX)))      return {1'b1, ACC_W'(ACC_MAX)};
    else if (sum < $signed((ACC_W+1)'(ACC_MIN))) return {1'b1, ACC_W'(ACC_MIN)};
    else                                         return {1'b0, sum[ACC_W-1:0]};
  endfunction

  assign add_w = sat_add(acc_q, dec_w.sval);

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (acc_clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (push_w) begin
      acc_d = add_w[ACC_W-1:0];
      sat_d = sat_q | add_w[ACC_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc_out = acc_q;
  assign acc_sat = sat_q;
`endif
endmodule

// File: tb/tb_sub4_result_stage.sv
// Randomised and directed bench for sub4_result_stage against a queue-based arithmetic model.
`timescale 1ns/1ps
module tb_sub4_result_stage;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [4:0] in_diff;
  logic       in_ready, out_valid, out_neg, out_zero;
  logic [3:0] out_mag;
  logic [4:0] out_sval;
`ifdef SUB4_ACCUM_EN
  logic              acc_clr;
  logic signed [7:0] acc_out;
  logic              acc_sat;
  int                m_acc = 0;
  int                m_sat = 0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int q[$];

  always #5 clk = ~clk;

  sub4_result_stage #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_diff   (in_diff),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_neg   (out_neg),
    .out_mag   (out_mag),
    .out_zero  (out_zero),
    .out_sval  (out_sval)
`ifdef SUB4_ACCUM_EN
    ,
    .acc_clr   (acc_clr),
    .acc_out   (acc_out),
    .acc_sat   (acc_sat)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected head fields come straight from the arithmetic value A-B = word-16.
  task automatic check_outputs();
    int v, en, em, ez, es;
    en = 0; em = 0; ez = 0; es = 0;
    if (q.size() > 0) begin
      v  = q[0] - 16;
      en = (v < 0);
      em = (v < 0 ? -v : v) % 16;
      ez = (v == 0);
      es = v & 31;
    end
    chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    chk("out_neg", int'(out_neg), en);
    chk("out_mag", int'(out_mag), em);
    chk("out_zero", int'(out_zero), ez);
    chk("out_sval", int'(out_sval), es);
`ifdef SUB4_ACCUM_EN
    chk("acc_out", int'(acc_out), m_acc);
    chk("acc_sat", int'(acc_sat), m_sat);
`endif
  endtask

  task automatic model_update();
    bit fin, fout;
    fin  = in_valid && (q.size() < DEPTH);
    fout = out_ready && (q.size() > 0);
`ifdef SUB4_ACCUM_EN
    if (acc_clr) begin
      m_acc = 0;
      m_sat = 0;
    end else if (fin) begin
      m_acc = m_acc + int'(in_diff) - 16;
      if (m_acc > 127)  begin m_acc = 127;  m_sat = 1; end
      if (m_acc < -128) begin m_acc = -128; m_sat = 1; end
    end
`endif
    if (fout) void'(q.pop_front());
    if (fin) q.push_back(int'(in_diff));
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] d, input logic r);
    in_valid  = v;
    in_diff   = d;
    out_ready = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0);
`ifdef SUB4_ACCUM_EN
    acc_clr = 1'b0;
`endif
    #2;
    check_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 2-5 into empty FIFO, visible the next cycle
    drive(1'b1, 5'b01101, 1'b0);
    step();
    drive(1'b0, 5'd0, 1'b1);
    chk("d034_valid", int'(out_valid), 1);
    chk("d034_neg", int'(out_neg), 1);
    chk("d034_mag", int'(out_mag), 3);
    chk("d034_zero", int'(out_zero), 0);
    chk("d034_sval", int'(out_sval), 5'b11101);
    step();

    // 7-7 and 0-15
    drive(1'b1, 5'b10000, 1'b0); step();
    drive(1'b1, 5'b00001, 1'b0); step();
    drive(1'b0, 5'd0, 1'b1);
    chk("d035_zero", int'(out_zero), 1);
    chk("d035_neg", int'(out_neg), 0);
    chk("d035_mag", int'(out_mag), 0);
    step();
    chk("d035b_neg", int'(out_neg), 1);
    chk("d035b_mag", int'(out_mag), 15);
    chk("d035b_sval", int'(out_sval), 5'b10001);
    step();

    // unreachable all-zero word
    drive(1'b1, 5'b00000, 1'b0); step();
    drive(1'b0, 5'd0, 1'b1);
    chk("d022_neg", int'(out_neg), 1);
    chk("d022_mag", int'(out_mag), 0);
    chk("d022_zero", int'(out_zero), 0);
    chk("d022_sval", int'(out_sval), 5'b10000);
    step();

    // fill to full, fifth word refused, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i * 3 + 17), 1'b0);
      step();
    end
    chk("full_in_ready", int'(in_ready), 0);
    drive(1'b0, 5'd0, 1'b1);
    step();
    chk("after_pop_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) step();

    // steady push/pop at occupancy 2, wraps the pointers
    drive(1'b1, 5'd9, 1'b0); step();
    drive(1'b1, 5'd22, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'($urandom_range(0, 31)), 1'b1);
      step();
    end
    drive(1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 2) != 0));
`ifdef SUB4_ACCUM_EN
      acc_clr = ($urandom_range(0, 24) == 0);
`endif
      step();
    end
`ifdef SUB4_ACCUM_EN
    acc_clr = 1'b0;
`endif

    // asynchronous reset with stored results
    drive(1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 3), 1'b0);
      step();
    end
    drive(1'b1, 5'd30, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sval", int'(out_sval), 0);
    chk("rst_out_mag", int'(out_mag), 0);
    q.delete();
`ifdef SUB4_ACCUM_EN
    m_acc = 0;
    m_sat = 0;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0);
    step();
    step();

`ifdef SUB4_ACCUM_EN
    // positive saturation, then clear beats a concurrent add
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'b11111, 1'b1);
      step();
    end
    drive(1'b0, 5'd0, 1'b1);
    chk("acc_pos_sat", int'(acc_out), 127);
    chk("acc_sat_set", int'(acc_sat), 1);
    drive(1'b1, 5'b00110, 1'b1);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    drive(1'b0, 5'd0, 1'b1);
    chk("acc_clr_val", int'(acc_out), 0);
    chk("acc_clr_sat", int'(acc_sat), 0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sub4_result_stage.md
SUB4_RESULT_STAGE -- requirements
Module: sub4_result_stage

Interface
REQ-001 Parameter DEPTH, default 4, meaning result FIFO entry count (power of two, 2..16).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  diff word present.
REQ-005 in_diff  input  5  A+~B+1 subtractor output; bit4 = no-borrow (1 means A>=B), bits3:0 = low difference.
REQ-006 in_ready  output  1  stage can accept in_diff this cycle.
REQ-007 out_valid  output  1  head result valid.
REQ-008 out_ready  input  1  consumer takes head result.
REQ-009 out_neg  output  1  head result negative (A<B).
REQ-010 out_mag  output  4  head result magnitude |A-B|.
REQ-011 out_zero  output  1  head result equals zero.
REQ-012 out_sval  output  5  head result as 5-bit two's complement A-B.

Function
REQ-013 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-014 in_ready SHALL equal !full; no same-cycle bypass of a full FIFO, even if out_ready=1.
REQ-015 Decode per accepted word: neg = ~in_diff[4]; sval = {~in_diff[4], in_diff[3:0]}; mag = neg ? (16 - in_diff[3:0]) mod 16 : in_diff[3:0]; zero = (in_diff == 5'b10000).
REQ-016 Decode occurs before storage; FIFO stores {neg, mag, zero, sval} (11 bits).
REQ-017 Latency: word accepted in cycle N into empty FIFO -> out_valid=1 with its result in cycle N+1.
REQ-018 Order preserved; out_* SHALL be stable while out_valid && !out_ready.
REQ-019 out_valid = (count != 0); count range 0..DEPTH; full = (count == DEPTH).
REQ-020 Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
REQ-021 Read/write pointers wrap modulo DEPTH.
REQ-022 Word 5'b00000 (unreachable from subtractor) decodes per REQ-015: neg=1, mag=0, zero=0, sval=-16; no error flag.
REQ-023 When out_valid=0, out_neg/out_mag/out_zero/out_sval SHALL be driven 0.

Reset
REQ-024 rst asserted: count, pointers cleared immediately; in_ready=1, out_valid=0, all out_* = 0.
REQ-025 Reset mid-operation discards all stored results; no transfer is recognised in a cycle where rst is high.
REQ-026 Storage array contents need no reset.

Configuration
REQ-027 Macro SUB4_ACCUM_EN SHALL, when defined, add ports acc_clr input 1, acc_out output 8 (signed), acc_sat output 1.
REQ-028 With SUB4_ACCUM_EN: each input transfer adds sign-extended sval to acc_out, saturating at +127/-128; acc_sat sticky set on any saturation.
REQ-029 With SUB4_ACCUM_EN: acc_clr synchronous, clears acc_out and acc_sat, takes priority over a same-cycle add; rst clears both.
REQ-030 Without SUB4_ACCUM_EN: ports and accumulator logic absent; all other behaviour identical.

Structure
REQ-031 Package sub4_pkg SHALL hold DIFF_W=5, MAG_W=4, ACC_W=8, ACC_MAX=127, ACC_MIN=-128 and the result-record typedef.
REQ-032 One sub-module sub4_fifo (parameterised DEPTH, width 11, async active-high reset) holds storage, pointers, count.
REQ-033 Decode and accumulator live in sub4_result_stage.

Verification
REQ-034 in_diff=5'b01101 (2-5), out_ready=1 -> next cycle out_neg=1, out_mag=3, out_zero=0, out_sval=5'b11101.
REQ-035 in_diff=5'b10000 (7-7) -> out_zero=1, out_neg=0, out_mag=0; in_diff=5'b00001 (0-15) -> out_neg=1, out_mag=15, out_sval=5'b10001.
REQ-036 out_ready=0, push 4 words -> in_ready=0 after 4th; 5th in_valid not accepted; then pop all in order, in_ready=1 after first pop.
REQ-037 count=2, simultaneous push/pop for 10 cycles -> count stays 2, pointer wrap exercised, order intact.
REQ-038 rst pulsed with 3 stored words -> out_valid=0, in_ready=1 same cycle without clock edge.
REQ-039 SUB4_ACCUM_EN: push 10 words of 5'b11111 (+15) -> acc_out=127, acc_sat=1; acc_clr with concurrent push -> acc_out=0, acc_sat=0.
